// File: rtl/rv0_alu_arb.sv
// Two-requester arbiter in front of the shared combinational ALU.
// Grants one request per cycle and returns each result through a one-entry result register.
module rv0_alu_arb #(
  parameter int XLEN       = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [1:0][31:0]     req_insn_i,
  input  logic [1:0][XLEN-1:0] req_addr_i,
  input  logic [1:0][XLEN-1:0] req_rdata1_i,
  input  logic [1:0][XLEN-1:0] req_rdata2_i,
  output logic [31:0]          alu_insn_o,
  output logic [XLEN-1:0]      alu_addr_o,
  output logic [XLEN-1:0]      alu_rdata1_o,
  output logic [XLEN-1:0]      alu_rdata2_o,
  input  logic [XLEN-1:0]      alu_wdata_i,
  output logic [1:0]           rsp_valid_o,
  input  logic [1:0]           rsp_ready_i,
  output logic [XLEN-1:0]      rsp_wdata_o,
  output logic                 busy_o
);

  logic            res_vld_q;
  logic            res_id_q;
  logic            prio_q;
  logic [XLEN-1:0] res_q;

  logic       can_accept;
  logic       drain;
  logic [1:0] grant;
  logic       gnt_id;

  assign drain = res_vld_q && rsp_ready_i[res_id_q];

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant      = 2'b00;
    can_accept = !res_vld_q || rsp_ready_i[res_id_q];
    // Grant is suppressed while in reset so req_ready_o and the ALU bus read zero.
    if (!rst_i && can_accept) begin
      case (req_valid_i)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (FIXED_PRIO || !prio_q) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    gnt_id = grant[1];
  end

  assign req_ready_o = grant;

  always_comb begin
    alu_insn_o   = '0;
    alu_addr_o   = '0;
    alu_rdata1_o = '0;
    alu_rdata2_o = '0;
    if (|grant) begin
      alu_insn_o   = req_insn_i[gnt_id];
      alu_addr_o   = req_addr_i[gnt_id];
      alu_rdata1_o = req_rdata1_i[gnt_id];
      alu_rdata2_o = req_rdata2_i[gnt_id];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_vld_q <= 1'b0;
      res_id_q  <= 1'b0;
      res_q     <= '0;
      prio_q    <= 1'b0;
    end else if (|grant) begin
      res_q     <= alu_wdata_i;
      res_id_q  <= gnt_id;
      res_vld_q <= 1'b1;
      if (!FIXED_PRIO) prio_q <= ~gnt_id;
    end else if (drain) begin
      res_vld_q <= 1'b0;
    end
  end

  always_comb begin
    rsp_valid_o = 2'b00;
    rsp_wdata_o = '0;
    if (!rst_i && res_vld_q) begin
      rsp_valid_o = res_id_q ? 2'b10 : 2'b01;
      rsp_wdata_o = res_q;
    end
  end

  assign busy_o = !rst_i && res_vld_q;

endmodule

// File: tb/tb_rv0_alu_arb.sv
// Directed bench for rv0_alu_arb: scoreboard of expected results, immediate-assertion checks.
module tb_rv0_alu_arb;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0][31:0]     req_insn;
  logic [1:0][XLEN-1:0] req_addr, req_rdata1, req_rdata2;
  logic [1:0]           rsp_ready;

  logic [1:0]      rr_req_ready, rr_rsp_valid, fp_req_ready, fp_rsp_valid;
  logic [31:0]     rr_alu_insn, fp_alu_insn;
  logic [XLEN-1:0] rr_alu_addr, rr_alu_rdata1, rr_alu_rdata2, rr_alu_wdata, rr_rsp_wdata;
  logic [XLEN-1:0] fp_alu_addr, fp_alu_rdata1, fp_alu_rdata2, fp_alu_wdata, fp_rsp_wdata;
  logic            rr_busy, fp_busy;

  // Reference ALU: result depends on address and both operands.
  assign rr_alu_wdata = rr_alu_rdata1 + rr_alu_rdata2 + rr_alu_addr;
  assign fp_alu_wdata = fp_alu_rdata1 + fp_alu_rdata2 + fp_alu_addr;

  rv0_alu_arb #(.XLEN(XLEN), .FIXED_PRIO(1'b0)) u_rr (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rr_req_ready),
    .req_insn_i(req_insn), .req_addr_i(req_addr), .req_rdata1_i(req_rdata1),
    .req_rdata2_i(req_rdata2), .alu_insn_o(rr_alu_insn), .alu_addr_o(rr_alu_addr),
    .alu_rdata1_o(rr_alu_rdata1), .alu_rdata2_o(rr_alu_rdata2), .alu_wdata_i(rr_alu_wdata),
    .rsp_valid_o(rr_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_wdata_o(rr_rsp_wdata),
    .busy_o(rr_busy)
  );

  rv0_alu_arb #(.XLEN(XLEN), .FIXED_PRIO(1'b1)) u_fp (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(fp_req_ready),
    .req_insn_i(req_insn), .req_addr_i(req_addr), .req_rdata1_i(req_rdata1),
    .req_rdata2_i(req_rdata2), .alu_insn_o(fp_alu_insn), .alu_addr_o(fp_alu_addr),
    .alu_rdata1_o(fp_alu_rdata1), .alu_rdata2_o(fp_alu_rdata2), .alu_wdata_i(fp_alu_wdata),
    .rsp_valid_o(fp_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_wdata_o(fp_rsp_wdata),
    .busy_o(fp_busy)
  );

  typedef struct packed {
    logic            id;
    logic [XLEN-1:0] data;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Fixed-priority instance checking is enabled only during its own section.
  logic fp_mode = 1'b0;
  int   fp_cnt  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input logic id);
    return req_rdata1[id] + req_rdata2[id] + req_addr[id];
  endfunction

  // One clock: check outputs at the negedge against the directed grant and the scoreboard.
  task automatic cycle(input logic [1:0] exp_gnt);
    sb_entry_t e;
    logic      id;
    @(negedge clk);
    if (rst) begin
      chk("reset_outputs", {rr_req_ready, rr_rsp_valid, rr_rsp_wdata, rr_busy}, '0);
      chk("reset_alu", {rr_alu_insn, rr_alu_addr, rr_alu_rdata1, rr_alu_rdata2}, '0);
      sb.delete();
    end else begin
      chk("req_ready", rr_req_ready, exp_gnt);
      if (exp_gnt == 2'b00) begin
        chk("alu_idle", {rr_alu_insn, rr_alu_addr, rr_alu_rdata1, rr_alu_rdata2}, '0);
      end else begin
        id = exp_gnt[1];
        chk("alu_drive", {rr_alu_insn, rr_alu_addr, rr_alu_rdata1, rr_alu_rdata2},
            {req_insn[id], req_addr[id], req_rdata1[id], req_rdata2[id]});
      end
      if (sb.size() > 0) begin
        chk("rsp_valid", rr_rsp_valid, sb[0].id ? 2'b10 : 2'b01);
        chk("rsp_wdata", rr_rsp_wdata, sb[0].data);
        chk("busy", rr_busy, 1'b1);
        if (rsp_ready[sb[0].id]) e = sb.pop_front();
      end else begin
        chk("rsp_idle", {rr_rsp_valid, rr_rsp_wdata, rr_busy}, '0);
      end
      if (exp_gnt != 2'b00) begin
        e.id   = exp_gnt[1];
        e.data = model(exp_gnt[1]);
        sb.push_back(e);
      end
      if (fp_mode) begin
        chk("fp_ready", fp_req_ready, 2'b01);
        chk("fp_alu_insn", fp_alu_insn, req_insn[0]);
        if (fp_cnt > 0) begin
          chk("fp_rsp_valid", fp_rsp_valid, 2'b01);
          chk("fp_rsp_wdata", fp_rsp_wdata, req_rdata1[0] + req_rdata2[0] + req_addr[0]);
        end
        fp_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic n, input logic [31:0] insn, input logic [XLEN-1:0] addr,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_insn[n]   = insn;
    req_addr[n]   = addr;
    req_rdata1[n] = a;
    req_rdata2[n] = b;
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < cycles; i++) cycle(2'b00);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    rsp_ready  = 2'b00;
    req_insn   = '0;
    req_addr   = '0;
    req_rdata1 = '0;
    req_rdata2 = '0;

    // Reset then idle
    do_reset(2);
    cycle(2'b00);

    // Single op: addi x1,x0,5 with 7+5
    set_req(1'b0, 32'h0050_0093, '0, 32'd7, 32'd5);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    cycle(2'b01);
    req_valid = 2'b00;
    cycle(2'b00);
    cycle(2'b00);

    // Round-robin contention: 1+1 vs 2+2, alternating grants
    do_reset(1);
    set_req(1'b0, 32'h0020_80b3, '0, 32'd1, 32'd1);
    set_req(1'b1, 32'h0021_0133, '0, 32'd2, 32'd2);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    cycle(2'b01);
    cycle(2'b10);
    cycle(2'b01);
    cycle(2'b10);
    req_valid = 2'b00;
    cycle(2'b00);
    cycle(2'b00);

    // Back-pressure: req1 result held while req0 waits
    do_reset(1);
    set_req(1'b1, 32'h0041_8193, 32'h100, 32'd3, 32'd4);
    set_req(1'b0, 32'h0000_0013, 32'h40, 32'd10, 32'd20);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    cycle(2'b10);
    req_valid = 2'b01;
    for (int i = 0; i < 3; i++) cycle(2'b00);
    rsp_ready = 2'b10;
    cycle(2'b01);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    cycle(2'b00);
    cycle(2'b00);

    // Fixed priority instance: req0 wins every cycle
    do_reset(1);
    set_req(1'b0, 32'h0031_81b3, 32'h8, 32'd5, 32'd6);
    set_req(1'b1, 32'h0042_0233, 32'h0, 32'd9, 32'd9);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    fp_mode   = 1'b1;
    cycle(2'b01);
    cycle(2'b10);
    cycle(2'b01);
    fp_mode   = 1'b0;
    req_valid = 2'b00;
    cycle(2'b00);
    cycle(2'b00);

    // Reset mid-operation: pending req0 result is discarded, priority returns to 0
    do_reset(1);
    set_req(1'b0, 32'h0050_0093, 32'h4, 32'd100, 32'd23);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    cycle(2'b01);
    req_valid = 2'b00;
    cycle(2'b00);
    rst = 1'b1;
    cycle(2'b00);
    rst       = 1'b0;
    rsp_ready = 2'b11;
    cycle(2'b00);
    set_req(1'b1, 32'h0000_0033, 32'h0, 32'd1, 32'd2);
    req_valid = 2'b11;
    cycle(2'b01);
    req_valid = 2'b00;
    cycle(2'b00);
    cycle(2'b00);

    chk("scoreboard_empty", 128'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv0_alu_arb.md
Name: rv0_alu_arb

Overview:
- Two-requester arbiter and result sequencer in front of the shared combinational integer ALU.
- Requester 0 is the main execute pipe; requester 1 is the auxiliary path (address generation / CSR-side computation).
- Grants one request per cycle using round-robin priority, drives the granted operands onto the ALU, and captures the ALU result in a one-entry result register.
- Returns the result to the owning requester through a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  synchronous reset, active-high
- req_valid_i  input  2  request valid; bit n belongs to requester n
- req_ready_o  output  2  request accepted this cycle (bit n = grant to requester n)
- req_insn_i  input  2x32  instruction word per requester
- req_addr_i  input  2xXLEN  instruction address per requester
- req_rdata1_i  input  2xXLEN  operand 1 per requester
- req_rdata2_i  input  2xXLEN  operand 2 / immediate per requester
- alu_insn_o  output  32  to ALU instruction input
- alu_addr_o  output  XLEN  to ALU address input
- alu_rdata1_o  output  XLEN  to ALU operand 1
- alu_rdata2_o  output  XLEN  to ALU operand 2
- alu_wdata_i  input  XLEN  ALU result (combinational, same cycle)
- rsp_valid_o  output  2  result valid for requester n
- rsp_ready_i  input  2  requester n consumes result
- rsp_wdata_o  output  XLEN  result data, shared by both requesters; qualified by rsp_valid_o
- busy_o  output  1  result register occupied

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk_i/rst_i.
- State: res_vld_q, res_id_q (1b), res_q (XLEN), prio_q (1b; index of the favoured requester).
- Reset values: res_vld_q=0, res_id_q=0, res_q=0, prio_q=0.
- Output values in reset: req_ready_o=0, rsp_valid_o=0, rsp_wdata_o=0, busy_o=0.
- Reset asserted mid-operation discards any held result; nothing is returned afterwards.
- can_accept = !res_vld_q || rsp_ready_i[res_id_q]. This permits drain and accept in the same cycle, giving a throughput of 1 op/cycle.
- Grant, combinational, only when can_accept:
  - Only one valid request: that requester is granted.
  - Both valid, FIXED_PRIO=0: the requester equal to prio_q is granted.
  - Both valid, FIXED_PRIO=1: requester 0 is granted.
  - At most one grant bit is set. req_ready_o = grant. req_ready_o never depends on rsp_ready_i of a requester that has no result pending.
- ALU drive: when a grant is made, the ALU outputs carry the granted requester's insn/addr/rdata1/rdata2. With no grant they are all-zero, so the ALU sees opcode 0.
- On a grant to requester n at edge k:
  - res_q <= alu_wdata_i, res_id_q <= n, res_vld_q <= 1.
  - Round-robin mode: prio_q <= ~n.
- On drain (res_vld_q && rsp_ready_i[res_id_q]) with no new grant: res_vld_q <= 0.
- Latency: request accepted in cycle k; rsp_valid_o[n] is asserted from cycle k+1 until consumed.
- rsp_valid_o[n] = res_vld_q && res_id_q==n. rsp_wdata_o = res_q while valid, 0 otherwise. busy_o = res_vld_q.
- Handshake rules:
  - A requester holds valid and its payload stable until it sees ready.
  - rsp_valid_o is held, with res_q unchanged, until the owner asserts ready.
  - rsp_ready_i asserted without a pending result is ignored.
- Stall: if the held result's owner keeps rsp_ready_i low, no new grant is made. The other requester stalls too; this is intentional, because the single result register is shared.
- Fairness: in round-robin mode, with both requesters continuously valid and responses drained every cycle, grants alternate 0,1,0,1,…
- Width rules: the ALU result is captured unmodified. XLEN=64 widens all XLEN buses and changes nothing else.

Test Plan:
- Reset then idle:
  - Stimulus: rst_i high for 2 cycles, all valids low.
  - Required: all outputs 0, busy_o=0, ALU outputs 0.
- Single op:
  - Stimulus: req0 insn=0x00500093 (addi x1,x0,5), rdata1=7, rdata2=5, rsp_ready=1.
  - Required: req_ready_o=01 in the same cycle; next cycle rsp_valid_o=01, rsp_wdata_o=12.
- Round-robin contention:
  - Stimulus: both requesters valid for 4 cycles, each with add; req0 operands 1+1, req1 operands 2+2; responses always ready.
  - Required: grants 0,1,0,1; results 2,4,2,4 on consecutive cycles.
- Back-pressure:
  - Stimulus: req1 granted, rsp_ready_i[1]=0 for 3 cycles while req0 is valid.
  - Required: rsp_valid_o=10 and the value stays stable; req_ready_o=00 for those cycles. When rsp_ready_i[1] rises, req0 is granted that same cycle.
- FIXED_PRIO=1:
  - Stimulus: both requesters valid for 3 cycles.
  - Required: req0 granted every cycle; req1 is never granted.
- Reset mid-operation:
  - Stimulus: result pending for req0 (rsp_ready low); assert rst_i for 1 cycle.
  - Required: rsp_valid_o=00 next cycle, prio_q=0, and the old result is never presented.
